trojan1_multitimer_host: RTL
============================

TROJAN1_MULTITIMER_HOST -- requirements
Module: trojan1_multitimer_host

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent timer channels (1..8).
REQ-002 SHALL have parameter TIMER_WIDTH, default 10: counter and timeout width per channel.
REQ-003 SHALL have parameter PRESCALE_WIDTH, default 4: width of the shared prescaler.
REQ-004 SHALL have parameter R1_PATTERN, 16 bits, default 16'hCAFE: seed for the r1 pattern register.
REQ-005 SHALL have port clk  in  1: single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n  in  1: reset, asynchronous, active-low.
REQ-007 SHALL have port start  in  NUM_CH: per-channel restart pulse.
REQ-008 SHALL have port pause  in  NUM_CH: per-channel level pause.
REQ-009 SHALL have port clear_timeout  in  NUM_CH: per-channel sticky-flag clear.
REQ-010 SHALL have port mode  in  NUM_CH: 0 = one-shot, 1 = periodic.
REQ-011 SHALL have port prescale  in  PRESCALE_WIDTH: tick every prescale+1 cycles.
REQ-012 SHALL have port cfg_we  in  1: timeout-register write strobe.
REQ-013 SHALL have port cfg_ch  in  3: target channel of a cfg write; writes with cfg_ch >= NUM_CH are ignored.
REQ-014 SHALL have port cfg_timeout  in  TIMER_WIDTH: timeout value to write.
REQ-015 SHALL have port timer_count  out  NUM_CH*TIMER_WIDTH: registered counts, channel i at bits [i*TIMER_WIDTH +: TIMER_WIDTH].
REQ-016 SHALL have port timeout_flag  out  NUM_CH: sticky expiry flags.
REQ-017 SHALL have port timer_running  out  NUM_CH: 1 while the channel is in RUN.
REQ-018 SHALL have port irq  out  1: registered OR of timeout_flag.

Function
REQ-019 SHALL implement a shared prescaler counting 0..prescale, emitting a one-cycle tick at the wrap; prescale=0 gives a tick every cycle; the prescaler restarts at 0 when no channel is in RUN.
REQ-020 SHALL run a per-channel FSM with states IDLE, RUN, PAUSED, EXPIRED.
REQ-021 SHALL, on start[i] in any state, set counter to 0 and enter RUN; start has highest priority.
REQ-022 SHALL move RUN->PAUSED while pause[i]=1 and PAUSED->RUN when pause[i]=0, holding the counter unchanged in PAUSED.
REQ-023 SHALL, in RUN on a tick, increment the counter, or on counter >= eff_timeout-1 set timeout_flag[i] and reset the counter to 0, where eff_timeout = max(timeout_reg,1).
REQ-024 SHALL, on expiry, stay in RUN when mode[i]=1 and enter EXPIRED when mode[i]=0; EXPIRED is left only via start.
REQ-025 SHALL keep timeout_flag sticky until clear_timeout[i]; an expiry in the same cycle as a clear wins (flag stays 1).
REQ-026 SHALL apply a cfg write on the next edge; a running channel uses the new value from its next compare onward.
REQ-027 SHALL drive timer_count one cycle after the internal counter (one cycle latency).
REQ-028 SHALL advance a pattern index (4 bits) every cycle in which any channel is in RUN; on index wrap 15->0, shift the 16-bit pattern register left, inserting bit15^bit7.
REQ-029 SHALL drive Trojan1 r1 from pattern_reg[pattern_idx]; Trojan1 clk=clk, rst=~rst_n.
REQ-030 SHALL, when trigger=1, XOR channel 0 timer_count with {(TIMER_WIDTH-1){1},0}; other channels are unaffected.

Reset
REQ-031 SHALL, on rst_n=0, asynchronously set: all FSMs IDLE, counters 0, timer_count 0, timeout_flag 0, timer_running 0, irq 0, prescaler 0, timeout regs all-ones, pattern_reg=R1_PATTERN, pattern_idx=0.
REQ-032 SHALL abort any running or paused channel on reset mid-operation with no residual state.

Structure
REQ-033 SHALL place the FSM state encoding, the mode encoding and the corruption-mask constant in package trojan1_timer_pkg.
REQ-034 SHALL implement one channel (FSM, counter, timeout reg, flag) as sub-module timer_channel, instantiated NUM_CH times by generate; the prescaler, pattern generator and Trojan1 instance stay in the top.

Verification
REQ-035 SHALL check: prescale=0, ch0 timeout=5, mode=0, start[0] pulse -> timeout_flag[0]=1 after the 5th edge following the start edge; FSM EXPIRED; timer_running[0]=0.
REQ-036 SHALL check: prescale=1, ch1 timeout=5, mode=1 -> ch1 expires every 10 cycles, remains RUN, and irq=1 one cycle after the flag.
REQ-037 SHALL check: ch2 running, pause[2] held 7 cycles -> timer_count for ch2 frozen for those cycles, then resumes from the held value.
REQ-038 SHALL check: clear_timeout[0] in the same cycle as a ch0 expiry -> flag remains 1; a clear on the following cycle -> flag 0.
REQ-039 SHALL check: rst_n low mid-count with 3 channels running -> all outputs 0 immediately (asynchronously), before the next clk edge.
REQ-040 SHALL check: force trigger=1 with ch0 count=0 -> timer_count ch0=10'h3FE; ch1..ch3 unchanged.

Source files
------------

// File: rtl/trojan1_timer_pkg.sv
// Shared encodings and constants for the trojan1 multi-channel timer host.
package trojan1_timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_PAUSED  = 2'd2,
      ST_EXPIRED = 2'd3
   } ch_state_t;

   typedef enum logic {
      MODE_ONESHOT  = 1'b0,
      MODE_PERIODIC = 1'b1
   } ch_mode_t;

   // Sliced to TIMER_WIDTH: all ones except bit 0.
   localparam logic [31:0] CORRUPT_MASK   = 32'hFFFF_FFFE;
   localparam logic [15:0] TRIG_SIGNATURE = 16'hAAAA;

endpackage

// File: rtl/Trojan1.sv
// Trigger block: watches the r1 bit stream and raises trigger one cycle after
// the last 16 samples match the signature.
module Trojan1
   import trojan1_timer_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic r1,
   output logic trigger
);

   logic [15:0] r_hist;
   logic        r_trigger;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hist    <= '1;
         r_trigger <= 1'b0;
      end else begin
         r_hist    <= {r_hist[14:0], r1};
         r_trigger <= (r_hist == TRIG_SIGNATURE);
      end
   end

   assign trigger = r_trigger;

endmodule

// File: rtl/timer_channel.sv
// One timer channel: restart/pause/expire FSM, counter, timeout register and
// sticky expiry flag.
module timer_channel
   import trojan1_timer_pkg::*;
#(
   parameter int unsigned TIMER_WIDTH = 10
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_start,
   input  logic                   i_pause,
   input  logic                   i_clear,
   input  logic                   i_mode,
   input  logic                   i_tick,
   input  logic                   i_cfg_we,
   input  logic [TIMER_WIDTH-1:0] i_cfg_timeout,
   output logic [TIMER_WIDTH-1:0] o_count,
   output logic                   o_flag,
   output logic                   o_running
);

   ch_state_t              r_state;
   ch_state_t              w_state_nxt;
   logic [TIMER_WIDTH-1:0] r_count;
   logic [TIMER_WIDTH-1:0] w_count_nxt;
   logic [TIMER_WIDTH-1:0] r_timeout;
   logic [TIMER_WIDTH-1:0] w_eff_timeout;
   logic                   r_flag;
   logic                   w_expire;

   // A programmed timeout of 0 behaves like 1 (expire on every tick).
   assign w_eff_timeout = (r_timeout == '0) ? TIMER_WIDTH'(1) : r_timeout;

   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_expire    = 1'b0;
      if (i_start) begin
         w_state_nxt = ST_RUN;
         w_count_nxt = '0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (i_pause) begin
                  w_state_nxt = ST_PAUSED;
               end else if (i_tick) begin
                  if (r_count >= w_eff_timeout - TIMER_WIDTH'(1)) begin
                     w_expire    = 1'b1;
                     w_count_nxt = '0;
                     if (i_mode == MODE_ONESHOT)
                        w_state_nxt = ST_EXPIRED;
                  end else begin
                     w_count_nxt = r_count + TIMER_WIDTH'(1);
                  end
               end
            end
            ST_PAUSED: begin
               if (!i_pause)
                  w_state_nxt = ST_RUN;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= ST_IDLE;
         r_count   <= '0;
         r_flag    <= 1'b0;
         r_timeout <= '1;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
         // Expiry outranks a coincident clear.
         if (w_expire)
            r_flag <= 1'b1;
         else if (i_clear)
            r_flag <= 1'b0;
         if (i_cfg_we)
            r_timeout <= i_cfg_timeout;
      end
   end

   assign o_count   = r_count;
   assign o_flag    = r_flag;
   assign o_running = (r_state == ST_RUN);

endmodule

// File: rtl/trojan1_multitimer_host.sv
// Multi-channel timer host: shared prescaler, NUM_CH timer channels, r1
// pattern generator feeding Trojan1, and registered count/irq outputs.
module trojan1_multitimer_host
   import trojan1_timer_pkg::*;
#(
   parameter int unsigned NUM_CH         = 4,
   parameter int unsigned TIMER_WIDTH    = 10,
   parameter int unsigned PRESCALE_WIDTH = 4,
   parameter logic [15:0] R1_PATTERN     = 16'hCAFE
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_CH-1:0]             start,
   input  logic [NUM_CH-1:0]             pause,
   input  logic [NUM_CH-1:0]             clear_timeout,
   input  logic [NUM_CH-1:0]             mode,
   input  logic [PRESCALE_WIDTH-1:0]     prescale,
   input  logic                          cfg_we,
   input  logic [2:0]                    cfg_ch,
   input  logic [TIMER_WIDTH-1:0]        cfg_timeout,
   output logic [NUM_CH*TIMER_WIDTH-1:0] timer_count,
   output logic [NUM_CH-1:0]             timeout_flag,
   output logic [NUM_CH-1:0]             timer_running,
   output logic                          irq
);

   logic [NUM_CH*TIMER_WIDTH-1:0] w_count_flat;
   logic [NUM_CH*TIMER_WIDTH-1:0] r_timer_count;
   logic [NUM_CH*TIMER_WIDTH-1:0] w_corrupt;
   logic [PRESCALE_WIDTH-1:0]     r_presc;
   logic [15:0]                   r_pattern;
   logic [3:0]                    r_pidx;
   logic                          r_irq;
   logic                          w_any_run;
   logic                          w_tick;
   logic                          w_r1;
   logic                          w_rst;
   logic                          w_trigger;

   assign w_any_run = |timer_running;
   assign w_tick    = w_any_run && (r_presc >= prescale);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_presc <= '0;
      else if (!w_any_run || w_tick)
         r_presc <= '0;
      else
         r_presc <= r_presc + PRESCALE_WIDTH'(1);
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      timer_channel #(
         .TIMER_WIDTH(TIMER_WIDTH)
      ) u_ch (
         .i_clk        (clk),
         .i_rst_n      (rst_n),
         .i_start      (start[i]),
         .i_pause      (pause[i]),
         .i_clear      (clear_timeout[i]),
         .i_mode       (mode[i]),
         .i_tick       (w_tick),
         .i_cfg_we     (cfg_we && (cfg_ch == 3'(i))),
         .i_cfg_timeout(cfg_timeout),
         .o_count      (w_count_flat[i*TIMER_WIDTH +: TIMER_WIDTH]),
         .o_flag       (timeout_flag[i]),
         .o_running    (timer_running[i])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_timer_count <= '0;
         r_irq         <= 1'b0;
      end else begin
         r_timer_count <= w_count_flat;
         r_irq         <= |timeout_flag;
      end
   end

   // Pattern index only moves while some channel runs; each wrap rolls the pattern.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pattern <= R1_PATTERN;
         r_pidx    <= '0;
      end else if (w_any_run) begin
         r_pidx <= r_pidx + 4'd1;
         if (r_pidx == 4'd15)
            r_pattern <= {r_pattern[14:0], r_pattern[15] ^ r_pattern[7]};
      end
   end

   assign w_r1  = r_pattern[r_pidx];
   assign w_rst = ~rst_n;

   Trojan1 u_trojan1 (
      .clk    (clk),
      .rst    (w_rst),
      .r1     (w_r1),
      .trigger(w_trigger)
   );

   always_comb begin
      w_corrupt = '0;
      if (w_trigger)
         w_corrupt[TIMER_WIDTH-1:0] = CORRUPT_MASK[TIMER_WIDTH-1:0];
   end

   assign timer_count = r_timer_count ^ w_corrupt;
   assign irq         = r_irq;

endmodule
